aes_ced_round_checker: RTL and testbench
========================================

Name: aes_ced_round_checker

Overview:
- Concurrent-error-detection checker that sits directly downstream of the AES state flattening stage.
- Each round it takes the flattened 128-bit primary-path and redundant-path outputs of four stages: SubBytes, ShiftRows, MixColumns and KeyXor.
- It compares them byte-by-byte in a two-stage pipeline, tracks round progress and raises a sticky alarm.
- On the first fault it logs the round, the stage and the byte mask.

Parameters:
- NR, 10: rounds per block; the final round is round NR.
- STAGE_EN, 4'b1111: per-stage compare enable. Bit 0 = SB, bit 1 = SR, bit 2 = MC, bit 3 = KX.
- SKIP_LAST_MC, 1: when 1, the MC compare is forced clean on round NR (no MixColumns in the final round).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin (or restart) block check
- clear  in  1  synchronous clear of alarm, log and state
- rnd_valid  in  1  current round's eight buses are valid this cycle
- sb_pri, sb_red  in  128 each  SubBytes primary / redundant, flattened (byte [r][c] at bits 32c+8r)
- sr_pri, sr_red  in  128 each  ShiftRows primary / redundant
- mc_pri, mc_red  in  128 each  MixColumns primary / redundant
- kx_pri, kx_red  in  128 each  KeyXor primary / redundant
- busy  out  1  FSM in RUN
- done  out  1  block finished (level)
- alarm  out  1  sticky fault flag
- seq_err  out  1  sticky protocol violation (rnd_valid outside RUN)
- rnd_cnt  out  4  current round number, 1..NR
- err_round  out  4  round of the first logged fault
- err_stage  out  2  stage of the first logged fault: 0 SB, 1 SR, 2 MC, 3 KX
- err_mask  out  16  byte mismatch mask of the logged stage; bit i = byte i = state[i%4][i/4]

Behaviour:
- Reset (rst_n low, async): FSM=IDLE; rnd_cnt=0; busy, done, alarm, seq_err=0; err_round=0, err_stage=0, err_mask=0; both pipeline registers cleared.
- FSM states: IDLE, RUN, DONE.
  - IDLE --start--> RUN, rnd_cnt=1.
  - RUN, accepted beat with rnd_cnt<NR: rnd_cnt+1.
  - RUN, accepted beat with rnd_cnt==NR: DONE.
  - DONE --start--> RUN, rnd_cnt=1.
  - start while in RUN: restart, rnd_cnt=1. Beats already in the pipeline still complete.
- Beat acceptance: rnd_valid in RUN. rnd_valid in IDLE or DONE is ignored and sets seq_err.
- P1 (cycle t+1 after beat at t):
  - Register four 16-bit masks: mask[i] = (pri byte i != red byte i), ANDed with the STAGE_EN bit.
  - MC mask forced to 0 when SKIP_LAST_MC=1 and the beat's round == NR.
  - The beat's round number is registered with the masks.
- P2 (cycle t+2):
  - Any mask nonzero → alarm=1.
  - If alarm was 0 beforehand, log err_round, err_stage (lowest index among failing stages) and err_mask (that stage's mask).
  - Later faults never overwrite the log.
- done rises at t+2 after the final beat. It holds until start or clear. busy=1 exactly while in RUN.
- clear: next edge returns to the reset state (all outputs, pipeline flushed). clear wins over start and rnd_valid in the same cycle; that beat is discarded.
- Simultaneous start and rnd_valid in IDLE: start taken, beat ignored, seq_err set.
- rnd_cnt saturates at NR in DONE; it never wraps.
- Back-to-back beats every cycle are supported; there is no backpressure.

Decomposition:
- Package aes_ced_pkg:
  - stage enum {ST_SB, ST_SR, ST_MC, ST_KX}
  - FSM state enum
  - NR_AES128 = 10
  - byte-index helper (i → row i%4, col i/4)
- Sub-module ced_byte_cmp: 128-bit pri/red in, 16-bit combinational mask out; instantiated four times.

Test Plan:
- Clean run: start, 10 beats with pri==red → done high 2 cycles after beat 10; alarm=0; rnd_cnt=10.
- SB fault: round 3, sb_pri byte 5 ^= 0x01 → alarm 2 cycles after that beat; err_round=3, err_stage=0, err_mask=16'h0020.
- Multi-stage fault: round 7, SR byte 0 and KX bytes 15 and 14 corrupted → err_stage=1, err_mask=16'h0001. A second fault in round 8 leaves the log unchanged.
- Last-round MC mismatch: mc_pri != mc_red in round 10 with SKIP_LAST_MC=1 → alarm=0. The same corruption in round 9 → alarm=1, err_round=9, err_stage=2.
- Protocol: rnd_valid in IDLE → seq_err=1, rnd_cnt=0. clear → seq_err=0. start asserted mid-RUN at round 5 → rnd_cnt=1.
- Reset mid-run: rst_n low during round 4 with alarm set → all outputs 0 immediately (async). clear coincident with a faulty beat → alarm stays 0.

Source files
------------

// File: rtl/aes_ced_pkg.sv
// Shared types and helpers for the AES concurrent-error-detection round checker.
// Stage codes double as the logged err_stage value.
package aes_ced_pkg;

  localparam int NR_AES128 = 10;

  typedef enum logic [1:0] {
    ST_SB = 2'd0,
    ST_SR = 2'd1,
    ST_MC = 2'd2,
    ST_KX = 2'd3
  } stage_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } fsm_e;

  // Byte i of the flattened state is state[i%4][i/4], stored at bit 32*col + 8*row.
  function automatic int byte_row(input int i);
    return i % 4;
  endfunction

  function automatic int byte_col(input int i);
    return i / 4;
  endfunction

  function automatic int byte_lsb(input int i);
    return 32 * byte_col(i) + 8 * byte_row(i);
  endfunction

endpackage

// File: rtl/ced_byte_cmp.sv
// Byte-wise comparison of one stage's primary and redundant flattened state.
// mask[i] is set when byte i differs between the two paths.
module ced_byte_cmp
  import aes_ced_pkg::*;
(
  input  logic [127:0] pri,
  input  logic [127:0] red,
  output logic [15:0]  mask
);

  for (genvar i = 0; i < 16; i++) begin : g_byte
    localparam int LSB = byte_lsb(i);
    assign mask[i] = (pri[LSB +: 8] != red[LSB +: 8]);
  end

endmodule

// File: rtl/aes_ced_round_checker.sv
// Round-by-round CED checker: compares primary/redundant paths of four AES stages,
// raises a sticky alarm and logs the first fault (round, stage, byte mask).
module aes_ced_round_checker
  import aes_ced_pkg::*;
#(
  parameter int         NR           = NR_AES128,
  parameter logic [3:0] STAGE_EN     = 4'b1111,
  parameter bit         SKIP_LAST_MC = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         clear,
  input  logic         rnd_valid,
  input  logic [127:0] sb_pri,
  input  logic [127:0] sb_red,
  input  logic [127:0] sr_pri,
  input  logic [127:0] sr_red,
  input  logic [127:0] mc_pri,
  input  logic [127:0] mc_red,
  input  logic [127:0] kx_pri,
  input  logic [127:0] kx_red,
  output logic         busy,
  output logic         done,
  output logic         alarm,
  output logic         seq_err,
  output logic [3:0]   rnd_cnt,
  output logic [3:0]   err_round,
  output logic [1:0]   err_stage,
  output logic [15:0]  err_mask
);

  localparam logic [3:0] NR_C = 4'(NR);

  // rnd_valid is a one-cycle strobe with no backpressure: a beat is accepted on
  // every cycle rnd_valid is high in RUN without clear; elsewhere it only flags seq_err.
  fsm_e            state_q, state_d;
  logic [3:0]      rnd_d;
  logic            beat;
  logic            last_beat;

  logic [3:0][15:0] raw_mask;
  logic [3:0][15:0] p1_mask_d, p1_mask_q;
  logic [3:0]       p1_round_q;
  logic             p1_last_q;
  logic             any_fail;
  stage_e           first_stage;

  assign beat      = rnd_valid && (state_q == S_RUN) && !clear;
  assign last_beat = beat && (rnd_cnt == NR_C) && !start;
  assign busy      = (state_q == S_RUN);

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_cnt;
    if (clear) begin
      state_d = S_IDLE;
      rnd_d   = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_RUN;
            rnd_d   = 4'd1;
          end
        end
        S_RUN: begin
          if (start) begin
            rnd_d = 4'd1;
          end else if (rnd_valid) begin
            if (rnd_cnt < NR_C) rnd_d = rnd_cnt + 4'd1;
            else                state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (start) begin
            state_d = S_RUN;
            rnd_d   = 4'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          rnd_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rnd_cnt <= 4'd0;
      seq_err <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_cnt <= rnd_d;
      if (clear)                                 seq_err <= 1'b0;
      else if (rnd_valid && state_q != S_RUN)    seq_err <= 1'b1;
    end
  end

  ced_byte_cmp u_cmp_sb (.pri(sb_pri), .red(sb_red), .mask(raw_mask[ST_SB]));
  ced_byte_cmp u_cmp_sr (.pri(sr_pri), .red(sr_red), .mask(raw_mask[ST_SR]));
  ced_byte_cmp u_cmp_mc (.pri(mc_pri), .red(mc_red), .mask(raw_mask[ST_MC]));
  ced_byte_cmp u_cmp_kx (.pri(kx_pri), .red(kx_red), .mask(raw_mask[ST_KX]));

  // The final AES round has no MixColumns, so its redundant MC bus is meaningless.
  always_comb begin
    p1_mask_d = '0;
    if (beat) begin
      for (int k = 0; k < 4; k++) begin
        p1_mask_d[k] = raw_mask[k] & {16{STAGE_EN[k]}};
      end
      if (SKIP_LAST_MC && rnd_cnt == NR_C) p1_mask_d[ST_MC] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_mask_q  <= '0;
      p1_round_q <= 4'd0;
      p1_last_q  <= 1'b0;
    end else if (clear) begin
      p1_mask_q  <= '0;
      p1_round_q <= 4'd0;
      p1_last_q  <= 1'b0;
    end else begin
      p1_mask_q  <= p1_mask_d;
      p1_round_q <= beat ? rnd_cnt : 4'd0;
      p1_last_q  <= last_beat;
    end
  end

  assign any_fail = |p1_mask_q;

  always_comb begin
    first_stage = ST_SB;
    for (int k = 3; k >= 0; k--) begin
      if (p1_mask_q[k] != '0) first_stage = stage_e'(k[1:0]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm     <= 1'b0;
      done      <= 1'b0;
      err_round <= 4'd0;
      err_stage <= 2'd0;
      err_mask  <= 16'd0;
    end else if (clear) begin
      alarm     <= 1'b0;
      done      <= 1'b0;
      err_round <= 4'd0;
      err_stage <= 2'd0;
      err_mask  <= 16'd0;
    end else begin
      if (any_fail) begin
        alarm <= 1'b1;
        if (!alarm) begin
          err_round <= p1_round_q;
          err_stage <= first_stage;
          err_mask  <= p1_mask_q[first_stage];
        end
      end
      if (start)          done <= 1'b0;
      else if (p1_last_q) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_ced_round_checker.sv
// Directed bench for aes_ced_round_checker: table of single-block fault scenarios
// plus hand-written sequences for protocol, restart, reset and clear corner cases.
module tb_aes_ced_round_checker;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         clear = 1'b0;
  logic         rnd_valid = 1'b0;
  logic [127:0] sb_pri = '0, sb_red = '0, sr_pri = '0, sr_red = '0;
  logic [127:0] mc_pri = '0, mc_red = '0, kx_pri = '0, kx_red = '0;
  logic         busy, done, alarm, seq_err;
  logic [3:0]   rnd_cnt, err_round;
  logic [1:0]   err_stage;
  logic [15:0]  err_mask;

  int tests = 0;
  int fails = 0;

  aes_ced_round_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .rnd_valid(rnd_valid),
    .sb_pri(sb_pri), .sb_red(sb_red), .sr_pri(sr_pri), .sr_red(sr_red),
    .mc_pri(mc_pri), .mc_red(mc_red), .kx_pri(kx_pri), .kx_red(kx_red),
    .busy(busy), .done(done), .alarm(alarm), .seq_err(seq_err),
    .rnd_cnt(rnd_cnt), .err_round(err_round), .err_stage(err_stage), .err_mask(err_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          fr;
    logic [63:0] cm;
    int          fr2;
    logic [63:0] cm2;
    logic        ex_alarm;
    logic [3:0]  ex_round;
    logic [1:0]  ex_stage;
    logic [15:0] ex_mask;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // cm packs per-stage byte corruption masks as {kx, mc, sr, sb}; corrupted bytes get ^8'h01.
  task automatic drive_beat(input logic [63:0] cm);
    logic [127:0] d, f;
    for (int k = 0; k < 4; k++) begin
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      f = '0;
      for (int i = 0; i < 16; i++) if (cm[16*k + i]) f[8*i] = 1'b1;
      case (k)
        0: begin sb_pri = d ^ f; sb_red = d; end
        1: begin sr_pri = d ^ f; sr_red = d; end
        2: begin mc_pri = d ^ f; mc_red = d; end
        default: begin kx_pri = d ^ f; kx_red = d; end
      endcase
    end
    rnd_valid = 1'b1;
    cycle();
    rnd_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"clean",      0, 64'h0,                   0, 64'h0,              1'b0, 4'd0, 2'd0, 16'h0000};
    vecs[1] = '{"sb_r3_b5",   3, 64'h0000_0000_0000_0020, 0, 64'h0,              1'b1, 4'd3, 2'd0, 16'h0020};
    vecs[2] = '{"multi_r7",   7, 64'hC000_0000_0001_0000, 8, 64'h0000_0000_0000_0004, 1'b1, 4'd7, 2'd1, 16'h0001};
    vecs[3] = '{"mc_last",   10, 64'h0000_FFFF_0000_0000, 0, 64'h0,              1'b0, 4'd0, 2'd0, 16'h0000};
    vecs[4] = '{"mc_r9",      9, 64'h0000_0F0F_0000_0000, 0, 64'h0,              1'b1, 4'd9, 2'd2, 16'h0F0F};
    vecs[5] = '{"kx_r1_b15",  1, 64'h8000_0000_0000_0000, 0, 64'h0,              1'b1, 4'd1, 2'd3, 16'h8000};

    // Reset state
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rnd", 32'(rnd_cnt), 0);
    chk("rst_log", {err_round, err_stage, err_mask}, 0);
    rst_n = 1'b1;
    cycle();

    // Protocol: beat in IDLE ignored
    drive_beat(64'h0000_0000_0000_FFFF);
    chk("idle_seq_err", 32'(seq_err), 1);
    chk("idle_rnd", 32'(rnd_cnt), 0);
    cycle(); cycle();
    chk("idle_no_alarm", 32'(alarm), 0);
    do_clear();
    chk("clear_seq_err", 32'(seq_err), 0);

    // start + rnd_valid together in IDLE
    start = 1'b1;
    drive_beat(64'h0000_0000_0000_0001);
    start = 1'b0;
    chk("st_rv_busy", 32'(busy), 1);
    chk("st_rv_rnd", 32'(rnd_cnt), 1);
    chk("st_rv_seq_err", 32'(seq_err), 1);
    cycle(); cycle();
    chk("st_rv_alarm", 32'(alarm), 0);

    // Restart mid-run at round 5
    for (int b = 1; b <= 4; b++) drive_beat(64'h0);
    chk("pre_restart_rnd", 32'(rnd_cnt), 5);
    do_start();
    chk("restart_rnd", 32'(rnd_cnt), 1);
    chk("restart_busy", 32'(busy), 1);

    // Table-driven full blocks
    foreach (vecs[v]) begin
      logic [63:0] cm;
      do_clear();
      chk({vecs[v].name, "_cleared"}, {alarm, err_round, err_stage, err_mask}, 0);
      do_start();
      chk({vecs[v].name, "_start_rnd"}, 32'(rnd_cnt), 1);
      for (int b = 1; b <= 10; b++) begin
        cm = (b == vecs[v].fr) ? vecs[v].cm : ((b == vecs[v].fr2) ? vecs[v].cm2 : 64'h0);
        drive_beat(cm);
        chk({vecs[v].name, "_rnd"}, 32'(rnd_cnt), (b < 10) ? b + 1 : 10);
        chk({vecs[v].name, "_alarm_t"}, 32'(alarm),
            (vecs[v].ex_alarm && vecs[v].fr != 0 && b >= vecs[v].fr + 1) ? 1 : 0);
      end
      chk({vecs[v].name, "_busy_end"}, 32'(busy), 0);
      chk({vecs[v].name, "_done_early"}, 32'(done), 0);
      cycle();
      chk({vecs[v].name, "_done"}, 32'(done), 1);
      chk({vecs[v].name, "_alarm"}, 32'(alarm), 32'(vecs[v].ex_alarm));
      chk({vecs[v].name, "_err_round"}, 32'(err_round), 32'(vecs[v].ex_round));
      chk({vecs[v].name, "_err_stage"}, 32'(err_stage), 32'(vecs[v].ex_stage));
      chk({vecs[v].name, "_err_mask"}, 32'(err_mask), 32'(vecs[v].ex_mask));
      cycle(); cycle();
      chk({vecs[v].name, "_done_hold"}, 32'(done), 1);
    end

    // Beat in DONE: ignored, counter saturated
    drive_beat(64'h0);
    chk("done_seq_err", 32'(seq_err), 1);
    chk("done_rnd_sat", 32'(rnd_cnt), 10);
    do_start();
    chk("done_restart_done", 32'(done), 0);
    chk("done_restart_rnd", 32'(rnd_cnt), 1);

    // Async reset mid-run with alarm set
    do_clear();
    do_start();
    drive_beat(64'h0);
    drive_beat(64'h0000_0000_0000_0100);
    drive_beat(64'h0);
    chk("prerst_alarm", 32'(alarm), 1);
    chk("prerst_rnd", 32'(rnd_cnt), 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_flags", {busy, done, alarm, seq_err}, 0);
    chk("async_rst_rnd", 32'(rnd_cnt), 0);
    chk("async_rst_log", {err_round, err_stage, err_mask}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // clear coincident with a faulty beat
    do_start();
    clear = 1'b1;
    drive_beat(64'hFFFF_FFFF_FFFF_FFFF);
    clear = 1'b0;
    cycle(); cycle(); cycle();
    chk("clr_beat_alarm", 32'(alarm), 0);
    chk("clr_beat_busy", 32'(busy), 0);
    chk("clr_beat_mask", 32'(err_mask), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
